// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 4-bit ALU between two
// requesters: accept -> one EXEC cycle -> registered response with optional timeout.
module alu_share_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_z,
    output logic       rsp_c,
    output logic [1:0] rsp_drop,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_out,
    input  logic       alu_z,
    input  logic       alu_c,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic       TIMEOUT_EN = (HOLD_MAX > 0) ? 1'b1 : 1'b0;
    localparam logic [7:0] HOLD_LAST  = (HOLD_MAX > 0) ? 8'(HOLD_MAX - 1) : 8'd0;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic       prio_r;
    logic       owner_r;
    logic [7:0] hold_cnt_r;
    logic [3:0] alu_op_r;
    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic [3:0] rsp_data_r;
    logic       rsp_z_r;
    logic       rsp_c_r;
    logic [1:0] rsp_valid_r;
    logic [1:0] rsp_drop_r;
    logic       busy_r;

    logic       grant_s;
    logic       accept_s;
    logic       taken_s;
    logic       timeout_s;
    logic       drop_s;
    logic [3:0] op_sel_s;
    logic [3:0] a_sel_s;
    logic [3:0] b_sel_s;

    // Grant selection, handshake decode and next-state logic
    always_comb begin
        grant_s   = 1'b0;
        req_ready = 2'b00;
        op_sel_s  = 4'd0;
        a_sel_s   = 4'd0;
        b_sel_s   = 4'd0;
        state_s   = state_r;

        if (req_valid == 2'b11) begin
            grant_s = prio_r;
        end else if (req_valid == 2'b10) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end

        if (grant_s) begin
            op_sel_s = req_op[7:4];
            a_sel_s  = req_a[7:4];
            b_sel_s  = req_b[7:4];
        end else begin
            op_sel_s = req_op[3:0];
            a_sel_s  = req_a[3:0];
            b_sel_s  = req_b[3:0];
        end

        accept_s  = (state_r == ST_IDLE) && (req_valid != 2'b00);
        taken_s   = rsp_ready[owner_r];
        timeout_s = TIMEOUT_EN && (hold_cnt_r == HOLD_LAST);
        // acceptance on the timeout edge wins over the drop
        drop_s    = (state_r == ST_RESP) && !taken_s && timeout_s;

        if (accept_s) begin
            req_ready = onehot2(grant_s);
        end else begin
            req_ready = 2'b00;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_RESP;
            ST_RESP: begin
                if (taken_s || timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, operand latch, result capture, hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prio_r      <= 1'b0;
            owner_r     <= 1'b0;
            hold_cnt_r  <= 8'd0;
            alu_op_r    <= 4'd0;
            alu_a_r     <= 4'd0;
            alu_b_r     <= 4'd0;
            rsp_data_r  <= 4'd0;
            rsp_z_r     <= 1'b0;
            rsp_c_r     <= 1'b0;
            rsp_valid_r <= 2'b00;
            rsp_drop_r  <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_op_r <= op_sel_s;
                        alu_a_r  <= a_sel_s;
                        alu_b_r  <= b_sel_s;
                        owner_r  <= grant_s;
                        prio_r   <= ~grant_s;
                    end
                end
                ST_EXEC: begin
                    rsp_data_r <= alu_out;
                    rsp_z_r    <= alu_z;
                    rsp_c_r    <= alu_c;
                    hold_cnt_r <= 8'd0;
                end
                ST_RESP: begin
                    if (!taken_s) begin
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                    end
                end
                default: ;
            endcase
            rsp_valid_r <= (state_s == ST_RESP) ? onehot2(owner_r) : 2'b00;
            rsp_drop_r  <= drop_s ? onehot2(owner_r) : 2'b00;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign alu_op    = alu_op_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_z     = rsp_z_r;
    assign rsp_c     = rsp_c_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_drop  = rsp_drop_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: two arbiters (HOLD_MAX 15 and 4) each driving a behavioural ALU,
// exercised with directed sequences and random payloads against a transaction-level model.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req_valid [2];
    logic [7:0] req_op    [2];
    logic [7:0] req_a     [2];
    logic [7:0] req_b     [2];
    logic [1:0] rsp_ready [2];
    wire  [1:0] req_ready [2];
    wire  [1:0] rsp_valid [2];
    wire  [1:0] rsp_drop  [2];
    wire  [3:0] rsp_data  [2];
    wire        rsp_z     [2];
    wire        rsp_c     [2];
    wire  [3:0] alu_op    [2];
    wire  [3:0] alu_a     [2];
    wire  [3:0] alu_b     [2];
    wire        busy      [2];
    logic [3:0] alu_out   [2];
    logic       alu_z     [2];
    logic       alu_c     [2];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference ALU: returns {carry, zero, result}
    function automatic logic [5:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] w;
        case (op)
            4'b0100: w = {1'b0, a} + {1'b0, b};
            4'b0110: begin
                w    = {1'b0, a} - {1'b0, b};
                w[4] = ~w[4];
            end
            4'b1000: w = {1'b0, a & b};
            4'b1001: w = {1'b0, a | b};
            4'b1010: w = {1'b0, a ^ b};
            default: w = {1'b0, a};
        endcase
        return {w[4], (w[3:0] == 4'd0), w[3:0]};
    endfunction

    always_comb {alu_c[0], alu_z[0], alu_out[0]} = alu_ref(alu_op[0], alu_a[0], alu_b[0]);
    always_comb {alu_c[1], alu_z[1], alu_out[1]} = alu_ref(alu_op[1], alu_a[1], alu_b[1]);

    alu_share_arbiter #(.HOLD_MAX(15)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_a(req_a[0]), .req_b(req_b[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_z(rsp_z[0]), .rsp_c(rsp_c[0]), .rsp_drop(rsp_drop[0]),
        .alu_op(alu_op[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_out(alu_out[0]), .alu_z(alu_z[0]), .alu_c(alu_c[0]),
        .busy(busy[0])
    );

    alu_share_arbiter #(.HOLD_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_a(req_a[1]), .req_b(req_b[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_z(rsp_z[1]), .rsp_c(rsp_c[1]), .rsp_drop(rsp_drop[1]),
        .alu_op(alu_op[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_out(alu_out[1]), .alu_z(alu_z[1]), .alu_c(alu_c[1]),
        .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input int g);
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic set_req(input int d, input int r, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[d][4*r +: 4] = op;
        req_a[d][4*r +: 4]  = a;
        req_b[d][4*r +: 4]  = b;
        req_valid[d][r]     = 1'b1;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, " ready"}, 32'(req_ready[d]), 32'd0);
        chk({tag, " rvalid"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, " data"}, 32'(rsp_data[d]), 32'd0);
        chk({tag, " zc"}, 32'({rsp_z[d], rsp_c[d]}), 32'd0);
        chk({tag, " drop"}, 32'(rsp_drop[d]), 32'd0);
        chk({tag, " aluop"}, 32'({alu_op[d], alu_a[d], alu_b[d]}), 32'd0);
        chk({tag, " busy"}, 32'(busy[d]), 32'd0);
    endtask

    // Full operation with responses taken immediately; caller has presented the payload
    task automatic serve(input int d, input int g, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input string tag);
        logic [5:0] e;
        e = alu_ref(op, a, b);
        rsp_ready[d] = 2'b11;
        #1;
        chk({tag, " grant"}, 32'(req_ready[d]), 32'(oh(g)));
        tick();
        req_valid[d][g] = 1'b0;
        #1;
        chk({tag, " exec ready"}, 32'(req_ready[d]), 32'd0);
        chk({tag, " exec busy"}, 32'(busy[d]), 32'd1);
        chk({tag, " exec rvalid"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, " exec drop"}, 32'(rsp_drop[d]), 32'd0);
        chk({tag, " alu in"}, 32'({alu_op[d], alu_a[d], alu_b[d]}), 32'({op, a, b}));
        tick();
        chk({tag, " rvalid"}, 32'(rsp_valid[d]), 32'(oh(g)));
        chk({tag, " result"}, 32'({rsp_c[d], rsp_z[d], rsp_data[d]}), 32'(e));
        chk({tag, " resp busy"}, 32'(busy[d]), 32'd1);
        tick();
        chk({tag, " idle busy"}, 32'(busy[d]), 32'd0);
        chk({tag, " idle rvalid"}, 32'(rsp_valid[d]), 32'd0);
    endtask

    // Operation with a held-off response: n_resp RESP cycles, rsp_ready switched to rdy_go in cycle ready_at
    task automatic hold_run(input int d, input int g, input logic [3:0] op, input logic [3:0] a,
                            input logic [3:0] b, input int n_resp, input int ready_at,
                            input logic [1:0] rdy_idle, input logic [1:0] rdy_go,
                            input logic [1:0] exp_drop, input string tag);
        logic [5:0] e;
        e = alu_ref(op, a, b);
        rsp_ready[d] = rdy_idle;
        #1;
        chk({tag, " grant"}, 32'(req_ready[d]), 32'(oh(g)));
        tick();
        req_valid[d][g] = 1'b0;
        #1;
        chk({tag, " exec ready"}, 32'(req_ready[d]), 32'd0);
        tick();
        for (int c = 1; c <= n_resp; c++) begin
            chk({tag, " hold rvalid"}, 32'(rsp_valid[d]), 32'(oh(g)));
            chk({tag, " hold result"}, 32'({rsp_c[d], rsp_z[d], rsp_data[d]}), 32'(e));
            chk({tag, " hold ready"}, 32'(req_ready[d]), 32'd0);
            chk({tag, " hold drop"}, 32'(rsp_drop[d]), 32'd0);
            if (c == ready_at) begin
                rsp_ready[d] = rdy_go;
            end
            tick();
        end
        chk({tag, " end rvalid"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, " end drop"}, 32'(rsp_drop[d]), 32'(exp_drop));
        chk({tag, " end busy"}, 32'(busy[d]), 32'd0);
        rsp_ready[d] = 2'b11;
    endtask

    logic [3:0] p_op [2];
    logic [3:0] p_a  [2];
    logic [3:0] p_b  [2];
    int         prio_m;
    logic [3:0] r_op, r_a, r_b;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 2'b00;
            req_op[d]    = 8'd0;
            req_a[d]     = 8'd0;
            req_b[d]     = 8'd0;
            rsp_ready[d] = 2'b11;
        end
        tick();
        tick();
        rst = 1'b0;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");

        // Single add: 3 + 4
        set_req(0, 0, 4'b0100, 4'd3, 4'd4);
        serve(0, 0, 4'b0100, 4'd3, 4'd4, "single");

        // Simultaneous requests after reset: requester 0 wins first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 0, 4'b0110, 4'd5, 4'd5);
        set_req(0, 1, 4'b1000, 4'd6, 4'd3);
        serve(0, 0, 4'b0110, 4'd5, 4'd5, "simul0");
        serve(0, 1, 4'b1000, 4'd6, 4'd3, "simul1");

        // Fairness: both requesters always valid, random payloads, grants alternate
        prio_m = 0;
        for (int r = 0; r < 2; r++) begin
            p_op[r] = 4'($urandom_range(15, 0));
            p_a[r]  = 4'($urandom_range(15, 0));
            p_b[r]  = 4'($urandom_range(15, 0));
            set_req(0, r, p_op[r], p_a[r], p_b[r]);
        end
        for (int k = 0; k < 12; k++) begin
            int g;
            g = prio_m;
            serve(0, g, p_op[g], p_a[g], p_b[g], "fair");
            prio_m  = 1 - g;
            p_op[g] = 4'($urandom_range(15, 0));
            p_a[g]  = 4'($urandom_range(15, 0));
            p_b[g]  = 4'($urandom_range(15, 0));
            set_req(0, g, p_op[g], p_a[g], p_b[g]);
        end

        // Backpressure on HOLD_MAX=15: owner not ready for 5 cycles, ready in the 6th
        hold_run(0, prio_m, p_op[prio_m], p_a[prio_m], p_b[prio_m], 6, 6, 2'b10, 2'b11, 2'b00, "bp");
        prio_m = 1 - prio_m;
        serve(0, prio_m, p_op[prio_m], p_a[prio_m], p_b[prio_m], "bp next");
        req_valid[0] = 2'b00;

        // Timeout on HOLD_MAX=4: four RESP cycles, then drop pulse; next request accepted at once
        r_op = 4'($urandom_range(15, 0));
        r_a  = 4'($urandom_range(15, 0));
        r_b  = 4'($urandom_range(15, 0));
        set_req(1, 0, r_op, r_a, r_b);
        hold_run(1, 0, r_op, r_a, r_b, 4, 0, 2'b10, 2'b10, 2'b01, "tmo");
        set_req(1, 1, 4'b1001, 4'd9, 4'd6);
        serve(1, 1, 4'b1001, 4'd9, 4'd6, "tmo next");
        chk("tmo drop width", 32'(rsp_drop[1]), 32'd0);

        // Ready arriving on the 4th cycle wins over the timeout
        set_req(1, 0, 4'b1010, 4'd5, 4'd5);
        hold_run(1, 0, 4'b1010, 4'd5, 4'd5, 4, 4, 2'b00, 2'b01, 2'b00, "tmo ack");
        tick();
        chk("tmo ack late drop", 32'(rsp_drop[1]), 32'd0);

        // Reset during EXEC
        set_req(0, 0, 4'b0100, 4'd3, 4'd4);
        tick();
        chk("rst exec busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        req_valid[0] = 2'b00;
        tick();
        rst = 1'b0;
        chk_zero(0, "rst exec");
        set_req(0, 0, 4'b0100, 4'd3, 4'd4);
        set_req(0, 1, 4'b0110, 4'd2, 4'd7);
        serve(0, 0, 4'b0100, 4'd3, 4'd4, "rst exec after");
        req_valid[0] = 2'b00;

        // Reset during RESP
        rsp_ready[0] = 2'b00;
        set_req(0, 0, 4'b0100, 4'd8, 4'd9);
        tick();
        req_valid[0] = 2'b00;
        tick();
        chk("rst resp rvalid", 32'(rsp_valid[0]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero(0, "rst resp");
        tick();
        chk("rst resp no drop", 32'(rsp_drop[0]), 32'd0);
        set_req(0, 0, 4'b1001, 4'd1, 4'd2);
        set_req(0, 1, 4'b1000, 4'd15, 4'd15);
        serve(0, 0, 4'b1001, 4'd1, 4'd2, "rst resp after");
        serve(0, 1, 4'b1000, 4'd15, 4'd15, "rst resp after1");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
